// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with parallel load,
// logical shifts, rotates, arithmetic right shift and an autonomous burst
// mode that serially replaces the whole word while streaming the old one out.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, highest priority
//   en         command strobe, honoured only while not busy
//   mode       command select (hold/load/shl/shr/rol/ror/asr/burst)
//   din        parallel load data
//   sin_msb    serial input entering at MSB (right shifts, burst)
//   sin_lsb    serial input entering at LSB (left shift)
//   dout       registered contents
//   sout_msb   dout MSB
//   sout_lsb   dout LSB, the serial output stream during burst
//   busy       high while a burst is in progress
//   done       one-cycle pulse after the last burst shift
//   shift_cnt  burst shifts completed in the current or last burst
module univ_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CNTW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    output logic [WIDTH-1:0] dout,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  shift_cnt
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [CNTW-1:0] cnt_nxt;
    logic done_nxt;
    logic last;
    // the shift in progress when the counter reads WIDTH-1 is the final one
    assign last = shift_cnt == CNTW'(WIDTH - 1);
    assign busy = state == BURST;
    assign sout_msb = dout[WIDTH-1];
    assign sout_lsb = dout[0];
    always_comb begin
        state_nxt = state;
        q_nxt = dout;
        cnt_nxt = shift_cnt;
        done_nxt = 1'b0;
        if (state == BURST) begin
            q_nxt = {sin_msb, dout[WIDTH-1:1]};
            cnt_nxt = shift_cnt + 1'b1;
            state_nxt = last ? IDLE : BURST;
            done_nxt = last;
        end else if (en) begin
            case (mode)
                3'b001: q_nxt = din;
                3'b010: q_nxt = {dout[WIDTH-2:0], sin_lsb};
                3'b011: q_nxt = {sin_msb, dout[WIDTH-1:1]};
                3'b100: q_nxt = {dout[WIDTH-2:0], dout[WIDTH-1]};
                3'b101: q_nxt = {dout[0], dout[WIDTH-1:1]};
                3'b110: q_nxt = {dout[WIDTH-1], dout[WIDTH-1:1]};
                3'b111: begin
                    state_nxt = BURST;
                    cnt_nxt = '0;
                end
                default: q_nxt = dout;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dout <= '0;
            done <= 1'b0;
            shift_cnt <= '0;
        end else begin
            state <= state_nxt;
            dout <= q_nxt;
            done <= done_nxt;
            shift_cnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed checks of univ_shift_reg at WIDTH 4, 8 and 16
module tb_univ_shift_reg;
    logic clk = 1'b0;
    logic reset, en, sin_msb, sin_lsb;
    logic [2:0] mode;
    logic [15:0] din;
    logic [3:0] d4;
    logic [7:0] d8;
    logic [15:0] d16;
    logic [2:0] c4;
    logic [3:0] c8;
    logic [4:0] c16;
    logic sm4, sl4, b4, dn4, sm8, sl8, b8, dn8, sm16, sl16, b16, dn16;
    int total = 0;
    int bad = 0;
    logic [15:0] pat = 16'h9A4D;
    logic [7:0] old = 8'hF0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .en(en), .mode(mode), .din(din[3:0]),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .dout(d4), .sout_msb(sm4), .sout_lsb(sl4),
        .busy(b4), .done(dn4), .shift_cnt(c4));
    univ_shift_reg #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .en(en), .mode(mode), .din(din[7:0]),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .dout(d8), .sout_msb(sm8), .sout_lsb(sl8),
        .busy(b8), .done(dn8), .shift_cnt(c8));
    univ_shift_reg #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .en(en), .mode(mode), .din(din),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .dout(d16), .sout_msb(sm16), .sout_lsb(sl16),
        .busy(b16), .done(dn16), .shift_cnt(c16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] m, input logic [15:0] d);
        en = 1'b1;
        mode = m;
        din = d;
        tick();
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 3'b001; din = 16'hFFFF; sin_msb = 1'b0; sin_lsb = 1'b0;
        tick(); tick();
        chk("rst_dout8", d8, 8'h00);
        chk("rst_busy8", b8, 0);
        chk("rst_done8", dn8, 0);
        chk("rst_cnt8", c8, 0);
        chk("rst_dout4", d4, 4'h0);
        chk("rst_dout16", d16, 16'h0);
        reset = 1'b0; en = 1'b0;
        tick();
        chk("post_rst_dout8", d8, 8'h00);
        chk("post_rst_busy8", b8, 0);
        chk("post_rst_cnt8", c8, 0);
        cmd(3'b001, 16'h00A5);
        chk("load8", d8, 8'hA5);
        sin_lsb = 1'b1;
        cmd(3'b010, 16'h0);
        chk("shl8", d8, 8'h4B);
        sin_msb = 1'b0;
        cmd(3'b011, 16'h0);
        chk("shr8", d8, 8'h25);
        chk("shr_msb8", sm8, 0);
        cmd(3'b000, 16'hFFFF);
        chk("hold8", d8, 8'h25);
        tick();
        chk("idle8", d8, 8'h25);
        cmd(3'b001, 16'h8081);
        cmd(3'b100, 16'h0);
        chk("rol8", d8, 8'h03);
        chk("rol4", d4, 4'h2);
        chk("rol16", d16, 16'h0103);
        cmd(3'b001, 16'h8081);
        cmd(3'b101, 16'h0);
        chk("ror8", d8, 8'hC0);
        chk("ror4", d4, 4'h8);
        chk("ror16", d16, 16'hC040);
        cmd(3'b001, 16'h0080);
        cmd(3'b110, 16'h0);
        chk("asr_neg8", d8, 8'hC0);
        cmd(3'b001, 16'h0040);
        cmd(3'b110, 16'h0);
        chk("asr_pos8", d8, 8'h20);
        cmd(3'b001, 16'h00F0);
        cmd(3'b111, 16'h0);
        chk("start_busy8", b8, 1);
        chk("start_dout8", d8, 8'hF0);
        chk("start_cnt8", c8, 0);
        chk("start_busy4", b4, 1);
        chk("start_busy16", b16, 1);
        for (int i = 0; i < 16; i++) begin
            if (i < 8) chk($sformatf("sout8_%0d", i), sl8, old[i]);
            sin_msb = pat[i];
            if (i == 3) begin
                en = 1'b1; mode = 3'b001; din = 16'hFFFF;
            end
            tick();
            en = 1'b0;
            chk($sformatf("busy4_%0d", i), b4, i < 3);
            chk($sformatf("done4_%0d", i), dn4, i == 3);
            chk($sformatf("busy8_%0d", i), b8, i < 7);
            chk($sformatf("done8_%0d", i), dn8, i == 7);
            chk($sformatf("cnt8_%0d", i), c8, i < 8 ? i + 1 : 8);
            chk($sformatf("busy16_%0d", i), b16, i < 15);
            chk($sformatf("done16_%0d", i), dn16, i == 15);
        end
        chk("burst4", d4, 4'hD);
        chk("burst8", d8, 8'h4D);
        chk("burst16", d16, 16'h9A4D);
        chk("cnt4_final", c4, 4);
        chk("cnt16_final", c16, 16);
        tick();
        chk("done16_drop", dn16, 0);
        chk("cnt8_hold", c8, 8);
        cmd(3'b111, 16'h0);
        sin_msb = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_pre_busy8", b8, 1);
        tick();
        chk("b2b_done8", dn8, 1);
        chk("b2b_idle8", b8, 0);
        cmd(3'b111, 16'h0);
        chk("b2b_busy8", b8, 1);
        chk("b2b_cnt8", c8, 0);
        chk("b2b_done_drop8", dn8, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_pre_cnt8", c8, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_dout8", d8, 8'h00);
        chk("abort_busy8", b8, 0);
        chk("abort_cnt8", c8, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("abort_done8_%0d", i), dn8, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
